uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's single-cycle ready strobe and stores it in a circular FIFO. A host or parser drains the FIFO through a read-enable / read-valid handshake. The block provides occupancy flags and a sticky overrun indication, so bytes are not lost silently when the consumer stalls.

Parameters:
DATA_W, 8, byte width; matches receiver data_out
DEPTH, 16, number of entries; must be a power of two, 2..256
AF_LEVEL, 12, almost-full threshold in entries; used only with the optional feature

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_data  input  DATA_W  byte from receiver (data_out)
wr_strobe  input  1  one-cycle write strobe (receiver ready pulse)
rd_en  input  1  consumer read request
rd_data  output  DATA_W  registered read data
rd_valid  output  1  one-cycle pulse; rd_data valid this cycle
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because FIFO was full
clr_overrun  input  1  clears overrun on next edge
almost_full  output  1  count >= AF_LEVEL (optional feature; tied 0 otherwise)

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at rising edge):
  - wr_ptr, rd_ptr and count return to 0.
  - empty=1; full=0; overrun=0; rd_valid=0; rd_data=0; almost_full=0.
  - Memory contents are don't-care.
  - Reset mid-stream discards all stored bytes. A strobe or read in the reset cycle is ignored.
- Write: wr_strobe=1 and (not full, or rd_en=1 with full) stores wr_data at wr_ptr; wr_ptr increments modulo DEPTH.
- Read: rd_en=1 and not empty loads mem[rd_ptr] into rd_data on the next edge. rd_valid=1 for exactly that following cycle. rd_ptr increments modulo DEPTH.
- Read latency: 1 cycle from the rd_en sample to rd_valid.
- rd_data holds its last value when no read occurs.
- Read on empty: ignored; no rd_valid, pointers unchanged. This applies even if wr_strobe is simultaneous, so a byte is not readable in its own write cycle.
- Write on full with no read: byte dropped; overrun set to 1; pointers and count unchanged.
- Simultaneous write and read when full: both take effect; count stays DEPTH; no overrun.
- Simultaneous write and read when partially filled: count unchanged.
- count: +1 on write only, -1 on read only; never exceeds DEPTH and never underflows.
- Flags: empty = (count==0) and full = (count==DEPTH), both derived from registered count and valid in the same cycle as count.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from count, not pointer comparison.
- Overrun: set by a dropped write. Cleared by clr_overrun=1. If a drop and clr_overrun occur in the same cycle, set wins (overrun stays 1).
- Strobe width: wr_strobe is sampled every cycle. A multi-cycle strobe writes once per cycle; the receiver guarantees a 1-cycle pulse.

Optional Feature:
Macro UART_RX_FIFO_ALMOST_FULL_EN.
- Defined: almost_full is registered, equal to (count >= AF_LEVEL) after each update; reset 0.
- Not defined: almost_full is constant 0 and AF_LEVEL is unused.
- Port list is identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - uart_byte_t typedef (logic [7:0])
  - default FIFO depth constant UART_RX_FIFO_DEPTH = 16
  - The receiver and transmitter import the same package.
- One sub-module, uart_fifo_mem: simple dual-port array with synchronous write and registered synchronous read, parameterised by DATA_W and DEPTH. All pointer, count and flag control stays in uart_rx_fifo.

Test Plan:
1. Reset, then strobe 0x55, 0xA3, 0x0F on separate cycles; pulse rd_en 3 times -> rd_valid three times carrying 0x55, 0xA3, 0x0F; empty=1 and count=0 at end.
2. Write 16 bytes 0x00..0x0F -> full=1, count=16; 17th strobe 0xFF -> overrun=1, count=16; drain returns 0x00..0x0F with no 0xFF.
3. Fill to full, then assert wr_strobe (0x77) and rd_en in the same cycle -> rd_data=0x00 next cycle, count stays 16, overrun stays 0; 0x77 is read last.
4. Empty FIFO, assert wr_strobe (0x3C) and rd_en together -> no rd_valid, count=1; next rd_en yields 0x3C.
5. Write 10 bytes, assert rst for 1 cycle mid-stream -> count=0, empty=1, overrun=0, rd_valid=0; subsequent rd_en gives no rd_valid.
6. With UART_RX_FIFO_ALMOST_FULL_EN and AF_LEVEL=12: write 11 bytes -> almost_full=0; 12th write -> almost_full=1; one read -> almost_full=0. After an overrun, clr_overrun=1 -> overrun=0 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and byte type used by receiver, transmitter and FIFO.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: dual-port array, synchronous write, registered synchronous read.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // read-before-write: a same-address read returns the old entry
  always_ff @(posedge clk)
    if (rst) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO with occupancy flags and sticky overrun.
// Optional registered almost_full enabled by UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_strobe,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_rd_valid, r_overrun;
  logic          w_rd, w_wr, w_drop;
  assign empty = r_count == '0;
  assign full = r_count == CW'(DEPTH);
  assign w_rd = rd_en && !empty;
  // a read in the same cycle frees the slot being written when full
  assign w_wr = wr_strobe && (!full || rd_en);
  assign w_drop = wr_strobe && full && !rd_en;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_rd_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_rd_valid <= w_rd;
      r_overrun <= w_drop || (r_overrun && !clr_overrun);
    end
  end
  uart_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .i_we(w_wr),
    .i_waddr(r_wr_ptr),
    .i_wdata(wr_data),
    .i_re(w_rd),
    .i_raddr(r_rd_ptr),
    .o_rdata(rd_data)
  );
  assign rd_valid = r_rd_valid;
  assign count = r_count;
  assign overrun = r_overrun;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic r_almost_full;
  always_ff @(posedge clk)
    if (rst) r_almost_full <= 1'b0;
    else r_almost_full <= w_count_nxt >= CW'(AF_LEVEL);
  assign almost_full = r_almost_full;
`else
  logic w_unused_af;
  assign w_unused_af = AF_LEVEL != 0;
  assign almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plan plus randomized traffic against a queue-based model.
module tb_uart_rx_fifo;
  import uart_pkg::*;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  logic clk = 1'b0;
  logic rst, wr_strobe, rd_en, clr_overrun;
  uart_byte_t wr_data, rd_data;
  logic rd_valid, empty, full, overrun, almost_full;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  uart_byte_t q[$];
  uart_byte_t m_rd = '0;
  bit m_rv = 1'b0;
  bit m_ovr = 1'b0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_strobe(wr_strobe),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .empty(empty),
    .full(full),
    .count(count),
    .overrun(overrun),
    .clr_overrun(clr_overrun),
    .almost_full(almost_full)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask
  task automatic step(bit r, bit ws, uart_byte_t d, bit re, bit clr);
    bit rd_ok, wr_ok;
    bit exp_af;
    rst = r;
    wr_strobe = ws;
    wr_data = d;
    rd_en = re;
    clr_overrun = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rd = '0;
      m_rv = 1'b0;
      m_ovr = 1'b0;
    end else begin
      rd_ok = re && q.size() > 0;
      wr_ok = ws && (q.size() < DEPTH || re);
      m_rv = rd_ok;
      if (rd_ok) m_rd = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (ws && !wr_ok) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    exp_af = !r && q.size() >= AF;
`else
    exp_af = 1'b0;
`endif
    #1;
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("overrun", overrun, m_ovr);
    chk("almost_full", almost_full, exp_af);
  endtask
  initial begin
    rst = 1'b1;
    wr_strobe = 1'b0;
    wr_data = '0;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_data", rd_data, 0);
    step(0, 1, 8'h55, 0, 0);
    step(0, 1, 8'hA3, 0, 0);
    step(0, 1, 8'h0F, 0, 0);
    step(0, 0, 0, 1, 0); chk("t1_b0", rd_data, 8'h55);
    step(0, 0, 0, 1, 0); chk("t1_b1", rd_data, 8'hA3);
    step(0, 0, 0, 1, 0); chk("t1_b2", rd_data, 8'h0F);
    chk("t1_count", count, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    chk("t2_full", full, 1);
    chk("t2_count", count, 16);
    step(0, 1, 8'hFF, 0, 0);
    chk("t2_overrun", overrun, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0);
      chk("t2_drain", rd_data, i);
    end
    step(0, 0, 0, 1, 0);
    chk("t2_no_ff", rd_valid, 0);
    step(0, 0, 0, 0, 1);
    chk("t6_clr", overrun, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'h77, 1, 0);
    chk("t3_data", rd_data, 8'h00);
    chk("t3_count", count, 16);
    chk("t3_overrun", overrun, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    chk("t3_last", rd_data, 8'h77);
    step(0, 1, 8'h3C, 1, 0);
    chk("t4_no_valid", rd_valid, 0);
    chk("t4_count", count, 1);
    step(0, 0, 0, 1, 0);
    chk("t4_data", rd_data, 8'h3C);
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
    step(1, 1, 8'hAA, 1, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    step(0, 0, 0, 1, 0);
    chk("t5_no_valid", rd_valid, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'h0B, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 1);
    chk("drop_clr_set_wins", overrun, 1);
    step(0, 0, 0, 0, 1);
    for (int p = 0; p < 3000; p++) begin
      automatic int wp = (p / 300) % 2 == 0 ? 80 : 30;
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 99) < wp,
           8'($urandom),
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 29) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
